// File: rtl/cdb_arbiter_if.sv
// Bundle of the CDB arbiter handshake and broadcast signals.
// master: functional units and CDB consumers. slave: the arbiter.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TAG_W   = 3
);
  localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC*TAG_W-1:0]  src_tag;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      writeCDB;
  logic [DATA_W-1:0]         dadoCDB;
  logic [TAG_W-1:0]          RS_Name;
  logic [SRC_W-1:0]          cdb_src;
  logic                      err_tag0;

  modport master (
    output src_valid, src_data, src_tag,
    input  src_ready, writeCDB, dadoCDB, RS_Name, cdb_src, err_tag0
  );

  modport slave (
    input  src_valid, src_data, src_tag,
    output src_ready, writeCDB, dadoCDB, RS_Name, cdb_src, err_tag0
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: per-source result FIFOs, round-robin grant,
// one registered broadcast per cycle to the register bank and RSs.
module cdb_arbiter #(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned TAG_W      = 3,
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input logic          clock,
  input logic          resetn,
  cdb_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0]  data_mem [NUM_SRC][FIFO_DEPTH];
  logic [TAG_W-1:0]   tag_mem  [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q [NUM_SRC];
  logic [PTR_W-1:0]   rd_ptr_q [NUM_SRC];
  logic [CNT_W-1:0]   count_q  [NUM_SRC];

  logic [NUM_SRC-1:0] ready;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] tag_zero;
  logic [NUM_SRC-1:0] not_empty;
  logic               any_tag0;

  logic               grant_valid;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W-1:0]   cand_idx;
  logic [SRC_W-1:0]   last_q;
  logic [DATA_W-1:0]  head_data;
  logic [TAG_W-1:0]   head_tag;

  logic               write_q;
  logic [DATA_W-1:0]  dado_q;
  logic [TAG_W-1:0]   name_q;
  logic [SRC_W-1:0]   src_q;
  logic               err_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Per-source handshake; ready depends on occupancy only (no pop bypass).
  always_comb begin
    ready     = '0;
    not_empty = '0;
    tag_zero  = '0;
    push      = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      ready[i]     = (count_q[i] < CNT_W'(FIFO_DEPTH)) && resetn;
      not_empty[i] = (count_q[i] != '0);
      tag_zero[i]  = (bus.src_tag[i*TAG_W +: TAG_W] == '0);
      // Tag-0 results complete the handshake but are dropped.
      push[i]      = bus.src_valid[i] && ready[i] && !tag_zero[i];
    end
    any_tag0 = |(bus.src_valid & ready & tag_zero);
  end

  // Round-robin grant: first non-empty FIFO after the last winner.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand_idx = SRC_W'((32'(last_q) + k) % NUM_SRC);
      if (!grant_valid && not_empty[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
    pop = '0;
    if (grant_valid) begin
      pop[grant_idx] = 1'b1;
    end
    head_data = data_mem[grant_idx][rd_ptr_q[grant_idx]];
    head_tag  = tag_mem[grant_idx][rd_ptr_q[grant_idx]];
  end

  // FIFO pointers and occupancy; reset discards all buffered results.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (push[i]) begin
          wr_ptr_q[i] <= ptr_inc(wr_ptr_q[i]);
        end
        if (pop[i]) begin
          rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
        end
        if (push[i] && !pop[i]) begin
          count_q[i] <= count_q[i] + CNT_W'(1);
        end else if (!push[i] && pop[i]) begin
          count_q[i] <= count_q[i] - CNT_W'(1);
        end
      end
    end
  end

  // FIFO storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        data_mem[i][wr_ptr_q[i]] <= bus.src_data[i*DATA_W +: DATA_W];
        tag_mem[i][wr_ptr_q[i]]  <= bus.src_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // Registered broadcast, round-robin pointer and sticky tag-0 error.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      write_q <= 1'b0;
      dado_q  <= '0;
      name_q  <= '0;
      src_q   <= '0;
      last_q  <= SRC_W'(NUM_SRC - 1);
      err_q   <= 1'b0;
    end else begin
      write_q <= grant_valid;
      err_q   <= err_q | any_tag0;
      if (grant_valid) begin
        dado_q <= head_data;
        name_q <= head_tag;
        src_q  <= grant_idx;
        last_q <= grant_idx;
      end else begin
        // Idle bus: tag and source read as zero, data holds.
        name_q <= '0;
        src_q  <= '0;
      end
    end
  end

  assign bus.src_ready = ready;
  assign bus.writeCDB  = write_q;
  assign bus.dadoCDB   = dado_q;
  assign bus.RS_Name   = name_q;
  assign bus.cdb_src   = src_q;
  assign bus.err_tag0  = err_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, contention, single result,
// backpressure, tag-0 error and mid-operation reset.
module tb_cdb_arbiter;
  logic clock;
  logic resetn;
  int   n_cmp;
  int   n_fail;

  cdb_arbiter_if #(.NUM_SRC(2), .DATA_W(16), .TAG_W(3)) bus ();

  cdb_arbiter #(
    .NUM_SRC   (2),
    .DATA_W    (16),
    .TAG_W     (3),
    .FIFO_DEPTH(2)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Observation word: {writeCDB, dadoCDB, RS_Name, cdb_src}.
  function automatic logic [20:0] cdb_now();
    return {bus.writeCDB, bus.dadoCDB, bus.RS_Name, bus.cdb_src};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [15:0] d0, input logic [2:0] t0,
                       input logic [15:0] d1, input logic [2:0] t1);
    bus.src_valid = v;
    bus.src_data  = {d1, d0};
    bus.src_tag   = {t1, t0};
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(2'b11, 16'h1111, 3'd1, 16'h2222, 3'd2);
    tick();
    tick();
    n_cmp++;
    if (bus.src_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 00", bus.src_ready);
    end
    n_cmp++;
    if (cdb_now() !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_cdb: got %h want 000000", cdb_now());
    end
    n_cmp++;
    if (bus.err_tag0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: got %b want 0", bus.err_tag0);
    end
    drive(2'b00, 16'h0, 3'd0, 16'h0, 3'd0);
    resetn = 1'b1;
    #1;
    n_cmp++;
    if (bus.src_ready !== 2'b11) begin
      n_fail++;
      $display("FAIL release_ready: got %b want 11", bus.src_ready);
    end
  endtask

  task automatic test_contention();
    logic [20:0] exp [4];
    exp[0] = {1'b1, 16'hAAAA, 3'd1, 1'b0};
    exp[1] = {1'b1, 16'hBBBB, 3'd2, 1'b1};
    exp[2] = {1'b1, 16'hCCCC, 3'd1, 1'b0};
    exp[3] = {1'b1, 16'hDDDD, 3'd2, 1'b1};
    drive(2'b11, 16'hAAAA, 3'd1, 16'hBBBB, 3'd2);
    tick();
    n_cmp++;
    if (cdb_now() !== 21'h0) begin
      n_fail++;
      $display("FAIL contention_idle: got %h want 000000", cdb_now());
    end
    drive(2'b11, 16'hCCCC, 3'd1, 16'hDDDD, 3'd2);
    for (int i = 0; i < 4; i++) begin
      tick();
      drive(2'b00, 16'h0, 3'd0, 16'h0, 3'd0);
      n_cmp++;
      if (cdb_now() !== exp[i]) begin
        n_fail++;
        $display("FAIL contention[%0d]: got %h want %h", i, cdb_now(), exp[i]);
      end
    end
    tick();
    n_cmp++;
    if (cdb_now() !== {1'b0, 16'hDDDD, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL contention_drain: got %h want %h", cdb_now(),
               {1'b0, 16'hDDDD, 3'd0, 1'b0});
    end
  endtask

  task automatic test_single();
    drive(2'b01, 16'h1234, 3'd1, 16'h0, 3'd0);
    tick();
    drive(2'b00, 16'h0, 3'd0, 16'h0, 3'd0);
    tick();
    n_cmp++;
    if (cdb_now() !== {1'b1, 16'h1234, 3'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL single_bcast: got %h want %h", cdb_now(), {1'b1, 16'h1234, 3'd1, 1'b0});
    end
    tick();
    n_cmp++;
    if (cdb_now() !== {1'b0, 16'h1234, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL single_idle: got %h want %h", cdb_now(), {1'b0, 16'h1234, 3'd0, 1'b0});
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]  exp_rdy [6];
    logic [20:0] exp_out [10];
    exp_rdy[0] = 2'b11; exp_rdy[1] = 2'b11; exp_rdy[2] = 2'b10;
    exp_rdy[3] = 2'b01; exp_rdy[4] = 2'b10; exp_rdy[5] = 2'b01;
    exp_out[0] = {1'b0, 16'h1234, 3'd0, 1'b0};
    exp_out[1] = {1'b1, 16'hB001, 3'd2, 1'b1};
    exp_out[2] = {1'b1, 16'hA001, 3'd1, 1'b0};
    exp_out[3] = {1'b1, 16'hB002, 3'd2, 1'b1};
    exp_out[4] = {1'b1, 16'hA002, 3'd1, 1'b0};
    exp_out[5] = {1'b1, 16'hB003, 3'd2, 1'b1};
    exp_out[6] = {1'b1, 16'hA004, 3'd1, 1'b0};
    exp_out[7] = {1'b1, 16'hB005, 3'd2, 1'b1};
    exp_out[8] = {1'b1, 16'hA006, 3'd1, 1'b0};
    exp_out[9] = {1'b0, 16'hA006, 3'd0, 1'b0};
    for (int e = 1; e <= 10; e++) begin
      if (e <= 6) begin
        n_cmp++;
        if (bus.src_ready !== exp_rdy[e-1]) begin
          n_fail++;
          $display("FAIL bp_ready[%0d]: got %b want %b", e, bus.src_ready, exp_rdy[e-1]);
        end
        drive(2'b11, 16'hA000 + 16'(e), 3'd1, 16'hB000 + 16'(e), 3'd2);
      end else begin
        drive(2'b00, 16'h0, 3'd0, 16'h0, 3'd0);
      end
      tick();
      n_cmp++;
      if (cdb_now() !== exp_out[e-1]) begin
        n_fail++;
        $display("FAIL bp_bcast[%0d]: got %h want %h", e, cdb_now(), exp_out[e-1]);
      end
    end
  endtask

  task automatic test_tag0();
    n_cmp++;
    if (bus.err_tag0 !== 1'b0) begin
      n_fail++;
      $display("FAIL tag0_pre: got %b want 0", bus.err_tag0);
    end
    drive(2'b10, 16'h0, 3'd0, 16'h5555, 3'd0);
    tick();
    drive(2'b00, 16'h0, 3'd0, 16'h0, 3'd0);
    n_cmp++;
    if (bus.err_tag0 !== 1'b1) begin
      n_fail++;
      $display("FAIL tag0_err: got %b want 1", bus.err_tag0);
    end
    tick();
    n_cmp++;
    if (cdb_now() !== {1'b0, 16'hA006, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL tag0_nobcast: got %h want %h", cdb_now(), {1'b0, 16'hA006, 3'd0, 1'b0});
    end
    drive(2'b01, 16'h7777, 3'd3, 16'h0, 3'd0);
    tick();
    drive(2'b00, 16'h0, 3'd0, 16'h0, 3'd0);
    tick();
    n_cmp++;
    if (cdb_now() !== {1'b1, 16'h7777, 3'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL tag0_after: got %h want %h", cdb_now(), {1'b1, 16'h7777, 3'd3, 1'b0});
    end
    n_cmp++;
    if (bus.err_tag0 !== 1'b1) begin
      n_fail++;
      $display("FAIL tag0_sticky: got %b want 1", bus.err_tag0);
    end
  endtask

  task automatic test_reset_mid();
    drive(2'b11, 16'h1111, 3'd1, 16'h2222, 3'd2);
    tick();
    drive(2'b11, 16'h3333, 3'd1, 16'h4444, 3'd2);
    tick();
    drive(2'b00, 16'h0, 3'd0, 16'h0, 3'd0);
    n_cmp++;
    if (cdb_now() !== {1'b1, 16'h2222, 3'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_bcast: got %h want %h", cdb_now(), {1'b1, 16'h2222, 3'd2, 1'b1});
    end
    #3;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (cdb_now() !== 21'h0) begin
      n_fail++;
      $display("FAIL mid_async_cdb: got %h want 000000", cdb_now());
    end
    n_cmp++;
    if ({bus.src_ready, bus.err_tag0} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_async_flags: got %b want 000", {bus.src_ready, bus.err_tag0});
    end
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (cdb_now() !== 21'h0) begin
        n_fail++;
        $display("FAIL mid_stale[%0d]: got %h want 000000", i, cdb_now());
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_tag0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
